can_bit_destuff: RTL and testbench

//  Removes CAN stuff bits from the sampled serial RX stream. Delivers a clean bit

---
 rtl/can_bit_destuff_if.sv | 24 ++
 rtl/can_bit_destuff.sv | 177 +++++++++++++++++
 tb/tb_can_bit_destuff.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_bit_destuff_if.sv
// Bus bundle between the sample logic and the CAN bit destuffer.
// master drives sampled bits and controls; slave is the destuffer.
interface can_bit_destuff_if;
  logic       sample_valid;
  logic       rx_bit;
  logic       stuff_en;
  logic       abort;
  logic       bit_out;
  logic       bit_valid;
  logic       stuff_drop;
  logic       stuff_err;
  logic       in_frame;
  logic [7:0] err_cnt;

  modport master (
    output sample_valid, rx_bit, stuff_en, abort,
    input  bit_out, bit_valid, stuff_drop, stuff_err, in_frame, err_cnt
  );

  modport slave (
    input  sample_valid, rx_bit, stuff_en, abort,
    output bit_out, bit_valid, stuff_drop, stuff_err, in_frame, err_cnt
  );
endinterface

// File: rtl/can_bit_destuff.sv
// CAN RX bit destuffer: removes stuff bits, flags stuff violations, detects bus idle.
// Optional saturating stuff-error counter enabled by defining DESTUFF_ERR_CNT_EN.
module can_bit_destuff #(
  parameter int RUN_LEN  = 5,
  parameter int IDLE_LEN = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  can_bit_destuff_if.slave   bus
);

  localparam int RW = $clog2(IDLE_LEN + 1);
  localparam logic [RW-1:0] ZERO_W = RW'(0);
  localparam logic [RW-1:0] ONE_W  = RW'(1);
  localparam logic [RW-1:0] RUN_W  = RW'(RUN_LEN);
  localparam logic [RW-1:0] IDLE_W = RW'(IDLE_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t        state_r;
  logic [RW-1:0] run_r;
  logic          last_r;
  logic          pass_r;
  logic          bit_out_r;
  logic          bit_valid_r;
  logic          stuff_drop_r;
  logic          stuff_err_r;
  logic          in_frame_r;

  logic [RW-1:0] run_inc_s;
  logic [RW-1:0] stuff_run_s;
  logic [RW-1:0] pass_run_s;
  logic [RW-1:0] ones_run_s;
  logic          err_hit_s;

  // Candidate run-counter values for each counting mode, plus the stuff-error condition
  always_comb begin
    run_inc_s   = (run_r >= IDLE_W) ? IDLE_W : run_r + ONE_W;
    // pass_r: previous sample was pass-through, so a stuffed run restarts at 1
    stuff_run_s = (!pass_r && (bus.rx_bit == last_r)) ? run_inc_s : ONE_W;
    pass_run_s  = bus.rx_bit ? (pass_r ? run_inc_s : ONE_W) : ZERO_W;
    ones_run_s  = bus.rx_bit ? run_inc_s : ZERO_W;
    err_hit_s   = !bus.abort && bus.sample_valid && (state_r == STUFF) &&
                  bus.stuff_en && (bus.rx_bit == last_r);
  end

  // Destuffing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      run_r        <= ZERO_W;
      last_r       <= 1'b1;
      pass_r       <= 1'b0;
      bit_out_r    <= 1'b1;
      bit_valid_r  <= 1'b0;
      stuff_drop_r <= 1'b0;
      stuff_err_r  <= 1'b0;
      in_frame_r   <= 1'b0;
    end else begin
      bit_valid_r  <= 1'b0;
      stuff_drop_r <= 1'b0;
      stuff_err_r  <= 1'b0;
      if (bus.abort) begin
        state_r    <= IDLE;
        run_r      <= ZERO_W;
        last_r     <= 1'b1;
        pass_r     <= 1'b0;
        in_frame_r <= 1'b0;
      end else if (bus.sample_valid) begin
        case (state_r)
          IDLE: begin
            if (!bus.rx_bit) begin
              state_r     <= RUN;
              run_r       <= ONE_W;
              last_r      <= 1'b0;
              pass_r      <= 1'b0;
              bit_out_r   <= 1'b0;
              bit_valid_r <= 1'b1;
              in_frame_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end
          RUN, STUFF: begin
            if ((state_r == STUFF) && bus.stuff_en) begin
              if (err_hit_s) begin
                stuff_err_r <= 1'b1;
                state_r     <= ERR;
                run_r       <= ZERO_W;
                in_frame_r  <= 1'b0;
              end else begin
                // Stuff bit is dropped but opens the next run
                stuff_drop_r <= 1'b1;
                last_r       <= bus.rx_bit;
                run_r        <= ONE_W;
                state_r      <= RUN;
                in_frame_r   <= 1'b1;
              end
            end else begin
              bit_valid_r <= 1'b1;
              bit_out_r   <= bus.rx_bit;
              last_r      <= bus.rx_bit;
              if (bus.stuff_en) begin
                pass_r     <= 1'b0;
                run_r      <= stuff_run_s;
                state_r    <= (stuff_run_s == RUN_W) ? STUFF : RUN;
                in_frame_r <= 1'b1;
              end else begin
                pass_r <= 1'b1;
                if (pass_run_s == IDLE_W) begin
                  state_r    <= IDLE;
                  run_r      <= ZERO_W;
                  last_r     <= 1'b1;
                  in_frame_r <= 1'b0;
                end else begin
                  state_r    <= RUN;
                  run_r      <= pass_run_s;
                  in_frame_r <= 1'b1;
                end
              end
            end
          end
          ERR: begin
            if (ones_run_s == IDLE_W) begin
              state_r <= IDLE;
              run_r   <= ZERO_W;
              last_r  <= 1'b1;
            end else begin
              state_r <= ERR;
              run_r   <= ones_run_s;
            end
            in_frame_r <= 1'b0;
          end
          default: begin
            state_r    <= IDLE;
            run_r      <= ZERO_W;
            last_r     <= 1'b1;
            in_frame_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.bit_out    = bit_out_r;
  assign bus.bit_valid  = bit_valid_r;
  assign bus.stuff_drop = stuff_drop_r;
  assign bus.stuff_err  = stuff_err_r;
  assign bus.in_frame   = in_frame_r;

`ifdef DESTUFF_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating stuff-error counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (err_hit_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.err_cnt = err_cnt_r;
`else
  assign bus.err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_can_bit_destuff.sv
// Self-checking bench for can_bit_destuff: directed scenarios plus randomized
// streams compared cycle by cycle against a queue-based reference model.
module tb_can_bit_destuff;
  localparam int RUN_LEN  = 5;
  localparam int IDLE_LEN = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  can_bit_destuff_if bus ();

  can_bit_destuff #(.RUN_LEN(RUN_LEN), .IDLE_LEN(IDLE_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: frame phase 0=idle 1=in frame 2=error wait
  int         m_phase;
  bit         q[$];          // raw bus bits of the current stuffed segment
  bit         m_pass;        // current segment is pass-through
  int         m_ones;
  logic       m_out, m_valid, m_drop, m_err;
  logic [7:0] m_cnt;

  function automatic int trail_run();
    int n = 0;
    if (q.size() == 0) return 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] == q[q.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  function automatic void model_reset();
    m_phase = 0; q.delete(); m_pass = 1'b0; m_ones = 0;
    m_out = 1'b1; m_valid = 1'b0; m_drop = 1'b0; m_err = 1'b0; m_cnt = 8'h00;
  endfunction

  function automatic void model_step(bit sv, bit rx, bit en, bit ab);
    m_valid = 1'b0; m_drop = 1'b0; m_err = 1'b0;
    if (ab) begin
      m_phase = 0;
      return;
    end
    if (!sv) return;
    case (m_phase)
      0: if (!rx) begin
        m_phase = 1; q.delete(); q.push_back(1'b0); m_pass = 1'b0;
        m_valid = 1'b1; m_out = 1'b0;
      end
      1: if (en && !m_pass && trail_run() == RUN_LEN) begin
        if (rx != q[q.size() - 1]) begin
          m_drop = 1'b1; q.push_back(rx);
        end else begin
          m_err = 1'b1; m_phase = 2; m_ones = 0;
`ifdef DESTUFF_ERR_CNT_EN
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
`endif
        end
      end else begin
        m_valid = 1'b1; m_out = rx;
        if (en) begin
          if (m_pass) q.delete();
          m_pass = 1'b0; q.push_back(rx);
        end else begin
          if (!m_pass) m_ones = 0;
          m_pass = 1'b1;
          m_ones = rx ? m_ones + 1 : 0;
          if (m_ones == IDLE_LEN) m_phase = 0;
        end
      end
      2: begin
        m_ones = rx ? m_ones + 1 : 0;
        if (m_ones == IDLE_LEN) m_phase = 0;
      end
      default: ;
    endcase
    if (q.size() > 16) void'(q.pop_front());
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_out, m_valid, m_drop, m_err, (m_phase == 1), m_cnt};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {bus.bit_out, bus.bit_valid, bus.stuff_drop, bus.stuff_err, bus.in_frame, bus.err_cnt};
  endfunction

  task automatic cyc(input bit sv, input bit rx, input bit en, input bit ab);
    bus.sample_valid = sv; bus.rx_bit = rx; bus.stuff_en = en; bus.abort = ab;
    model_step(sv, rx, en, ab);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    if (obs_vec() !== 13'b1_0000_0000_0000) begin
      tests_failed++; $display("FAIL reset: got %b expected %b", obs_vec(), 13'b1_0000_0000_0000);
    end
    tests_run++;
  endtask

  task automatic test_basic();
    logic [6:0] seq = 7'b1101010;
    int nv = 0;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b1, seq[i], 1'b1, 1'b0);
      if (bus.bit_valid) nv++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++; $display("FAIL basic bit %0d: got %b expected %b", 6 - i, obs_vec(), exp_vec());
      end
      tests_run++;
    end
    if (nv !== 5) begin
      tests_failed++; $display("FAIL basic count: got %0d expected 5", nv);
    end
    tests_run++;
  endtask

  task automatic test_stuff_drop();
    logic [10:0] seq = 11'b00000111110;
    do_reset();
    for (int i = 10; i >= 0; i--) begin
      cyc(1'b1, seq[i], 1'b1, 1'b0);
      if (obs_vec() !== exp_vec()) begin
        tests_failed++; $display("FAIL stuff_drop bit %0d: got %b expected %b", 10 - i, obs_vec(), exp_vec());
      end
      tests_run++;
      if (i == 5 || i == 0) begin
        if ({bus.stuff_drop, bus.bit_valid} !== 2'b10) begin
          tests_failed++; $display("FAIL stuff_drop pulse bit %0d: got %b expected 10", 10 - i, {bus.stuff_drop, bus.bit_valid});
        end
        tests_run++;
      end
    end
  endtask

  task automatic test_stuff_err();
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    if ({bus.stuff_err, bus.bit_valid, bus.in_frame} !== 3'b100) begin
      tests_failed++; $display("FAIL stuff_err pulse: got %b expected 100", {bus.stuff_err, bus.bit_valid, bus.in_frame});
    end
    tests_run++;
    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      if (obs_vec() !== exp_vec()) begin
        tests_failed++; $display("FAIL stuff_err idle %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      tests_run++;
    end
`ifdef DESTUFF_ERR_CNT_EN
    if (bus.err_cnt !== 8'h01) begin
      tests_failed++; $display("FAIL stuff_err cnt: got %h expected 01", bus.err_cnt);
    end
`else
    if (bus.err_cnt !== 8'h00) begin
      tests_failed++; $display("FAIL stuff_err cnt: got %h expected 00", bus.err_cnt);
    end
`endif
    tests_run++;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    if ({bus.bit_valid, bus.in_frame} !== 2'b11) begin
      tests_failed++; $display("FAIL stuff_err new SOF: got %b expected 11", {bus.bit_valid, bus.in_frame});
    end
    tests_run++;
  endtask

  task automatic test_passthrough();
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, (i >= 7), 1'b0, 1'b0);
      if (obs_vec() !== exp_vec()) begin
        tests_failed++; $display("FAIL passthrough bit %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      tests_run++;
    end
    if ({bus.in_frame, bus.bit_valid, bus.bit_out} !== 3'b011) begin
      tests_failed++; $display("FAIL passthrough end: got %b expected 011", {bus.in_frame, bus.bit_valid, bus.bit_out});
    end
    tests_run++;
  endtask

  task automatic test_abort_reset();
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    if ({bus.bit_valid, bus.in_frame, bus.bit_out} !== 3'b001) begin
      tests_failed++; $display("FAIL abort: got %b expected 001", {bus.bit_valid, bus.in_frame, bus.bit_out});
    end
    tests_run++;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    bus.sample_valid = 1'b1; bus.rx_bit = 1'b0;
    do_reset();
    bus.sample_valid = 1'b0;
    if (obs_vec() !== 13'b1_0000_0000_0000) begin
      tests_failed++; $display("FAIL reset mid-frame: got %b expected %b", obs_vec(), 13'b1_0000_0000_0000);
    end
    tests_run++;
  endtask

  task automatic test_random();
    bit rx = 1'b1;
    bit en = 1'b1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) >= 80) rx = ~rx;
      if ($urandom_range(0, 99) < 2) en = ~en;
      cyc(($urandom_range(0, 3) != 0), rx, en, ($urandom_range(0, 199) == 0));
      if (obs_vec() !== exp_vec()) begin
        tests_failed++; $display("FAIL random cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      tests_run++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int e = 0; e < 256; e++) begin
      for (int i = 0; i < 17; i++) begin
        cyc(1'b1, (i >= 6), 1'b1, 1'b0);
        if (obs_vec() !== exp_vec()) begin
          tests_failed++; $display("FAIL back_to_back err %0d bit %0d: got %b expected %b", e, i, obs_vec(), exp_vec());
        end
        tests_run++;
      end
    end
`ifdef DESTUFF_ERR_CNT_EN
    if (bus.err_cnt !== 8'hFF) begin
      tests_failed++; $display("FAIL back_to_back sat: got %h expected FF", bus.err_cnt);
    end
`else
    if (bus.err_cnt !== 8'h00) begin
      tests_failed++; $display("FAIL back_to_back cnt: got %h expected 00", bus.err_cnt);
    end
`endif
    tests_run++;
  endtask

  initial begin
    bus.sample_valid = 1'b0; bus.rx_bit = 1'b1; bus.stuff_en = 1'b1; bus.abort = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_stuff_drop();
    test_stuff_err();
    test_passthrough();
    test_abort_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
